// File: rtl/logic_slice_seq_pkg.sv
// Shared encodings for the slice-serial logic unit and its gate slice.
package logic_slice_seq_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Slice index width: enough bits to count slices, never fewer than one.
  function automatic int idx_width(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/logic_slice_seq_gate_slice.sv
// Purely combinational SLICE-bit gate slice shared by slice-serial blocks.
module ls_gate_slice
  import logic_slice_seq_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_t              op,
  output logic [SLICE-1:0] y
);

  // Bitwise gate selected by op; no bit interacts with its neighbours.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_slice_seq.sv
// Multi-cycle bitwise logic unit: walks WIDTH-bit operands through one
// SLICE-bit gate slice per clock, LSB slice first, with start/busy/done.
module logic_slice_seq
  import logic_slice_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int NSL   = WIDTH / SLICE;
  localparam int IDX_W = idx_width(NSL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  state_t             state;
  state_t             state_next;
  op_t                op_l;
  logic [WIDTH-1:0]   a_l;
  logic [WIDTH-1:0]   b_l;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [IDX_W-1:0]   idx;
  logic [SLICE-1:0]   a_sl;
  logic [SLICE-1:0]   b_sl;
  logic [SLICE-1:0]   y_sl;
  logic               accept;
  logic               last;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (state == ST_RUN) && (idx == LAST_IDX);
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  ls_gate_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_l),
    .y  (y_sl)
  );

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: RUN until the last slice, DONE for one cycle, then rerun or idle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (idx == LAST_IDX) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Select the current operand slices from the latched copies.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int s = 0; s < NSL; s++) begin
      if (idx == IDX_W'(s)) begin
        a_sl = a_l[s*SLICE +: SLICE];
        b_sl = b_l[s*SLICE +: SLICE];
      end
    end
  end

  // Merge the gate output into the accumulator at the current slice position.
  always_comb begin
    acc_next = acc;
    for (int s = 0; s < NSL; s++) begin
      if (idx == IDX_W'(s)) acc_next[s*SLICE +: SLICE] = y_sl;
    end
  end

  // Operand latches, slice walk and result registers; y/zero move only on the done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_l <= OP_AND;
      a_l  <= '0;
      b_l  <= '0;
      idx  <= '0;
      acc  <= '0;
      y    <= '0;
      zero <= 1'b1;
    end else if (accept) begin
      op_l <= op_t'(op);
      a_l  <= a;
      b_l  <= b;
      idx  <= '0;
      acc  <= '0;
    end else if (state == ST_RUN) begin
      acc <= acc_next;
      if (last) begin
        y    <= acc_next;
        zero <= (acc_next == '0);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
